// File: rtl/threshold_cutter_pkg.sv
// Shared constants, FSM state encoding and burst-plan payload for the threshold-cutter block reader.
package threshold_cutter_pkg;

    localparam int unsigned DATA_WIDTH      = 256;
    localparam int unsigned BLOCK_DEPTH     = 400;
    localparam int unsigned BURST_LEN       = 16;
    localparam int unsigned DATA_BYTE_SHIFT = 5;
    localparam int unsigned BLOCK_BIT_OFF   = 9;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned BEAT_W = 9;
    localparam int unsigned REM_W  = $clog2(BLOCK_DEPTH + 2);

    localparam logic [2:0]  AXI_SIZE_32B   = 3'b101;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [63:0] PRESET_SEQUENCE = 64'h0001020304050607;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_FLUSH
    } rd_state_e;

    typedef struct packed {
        logic [LEN_W-1:0]  arlen;
        logic [BEAT_W-1:0] beats;
        logic [ADDR_W-1:0] next_addr;
        logic              last_burst;
    } burst_plan_t;

    // Marker table is eight bytes; the writer's marker for block n is bit 0 of byte n.
    function automatic logic marker_bit(input logic [2:0] blk);
        logic [63:0] seq;
        seq = PRESET_SEQUENCE;
        return seq[{blk, 3'b000}];
    endfunction

endpackage

// File: rtl/axi_burst_planner.sv
// Sizes the next AR burst from the words still owed and the current byte address.
module axi_burst_planner
    import threshold_cutter_pkg::*;
(
    input  logic [REM_W-1:0]  remaining,
    input  logic [ADDR_W-1:0] cur_addr,
    output burst_plan_t       plan
);

    logic [BEAT_W-1:0] beats;

    always_comb begin
        if (remaining > REM_W'(BURST_LEN)) begin
            beats = BEAT_W'(BURST_LEN);
        end else begin
            beats = BEAT_W'(remaining);
        end
        plan.arlen      = LEN_W'(beats - BEAT_W'(1));
        plan.beats      = beats;
        plan.next_addr  = cur_addr + (ADDR_W'(beats) << DATA_BYTE_SHIFT);
        plan.last_burst = (remaining <= REM_W'(BURST_LEN));
    end

endmodule

// File: rtl/threshold_block_axi_reader.sv
// AXI4 read master draining one threshold-cutter block into a valid/ready stream.
// Optional `MARKER_CHECK_EN verifies the writer's marker bit on the final word.
module threshold_block_axi_reader
    import threshold_cutter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_start,
    input  logic [ADDR_W-1:0]     araddr_start,
    output logic [ID_W-1:0]       m_axi_arid,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [LEN_W-1:0]      m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_W-1:0]       m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  drop
);

    rd_state_e         state, state_d;
    logic [REM_W-1:0]  remaining, rem_d;
    logic [ADDR_W-1:0] cur_addr, cur_d, nxt_addr, start_word, pend_addr;
    logic [BEAT_W-1:0] beat_cnt;
    logic              last_burst, pend_valid;
    logic              start, store_req, drop_d, done_d;
    logic              beat, final_beat, beat_err;
    burst_plan_t       plan;

    assign m_axi_arid    = '0;
    assign m_axi_arsize  = AXI_SIZE_32B;
    assign m_axi_arburst = AXI_BURST_INCR;

    // Single output register: accept a beat whenever it is empty or being drained.
    assign m_axi_rready = (state == ST_R) && (!out_valid || out_ready);
    assign beat         = m_axi_rvalid && m_axi_rready;
    assign final_beat   = (beat_cnt == BEAT_W'(1));

`ifdef MARKER_CHECK_EN
    logic [2:0] blk_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_sel <= '0;
        end else if (start) begin
            blk_sel <= start_word[BLOCK_BIT_OFF +: 3];
        end
    end
`endif

    always_comb begin
        beat_err = (m_axi_rlast != final_beat) || (m_axi_rresp != 2'b00) || (m_axi_rid != '0);
`ifdef MARKER_CHECK_EN
        if ((remaining == REM_W'(1)) && (m_axi_rdata[0] != marker_bit(blk_sel))) begin
            beat_err = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        rem_d      = remaining;
        cur_d      = cur_addr;
        start      = 1'b0;
        start_word = araddr_start;
        done_d     = 1'b0;
        store_req  = 1'b0;
        drop_d     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_valid) begin
                    start      = 1'b1;
                    start_word = pend_addr;
                end else if (read_start) begin
                    start = 1'b1;
                end
            end
            ST_AR: begin
                if (m_axi_arvalid && m_axi_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (beat) begin
                    rem_d = remaining - REM_W'(1);
                    if (final_beat) begin
                        cur_d   = nxt_addr;
                        state_d = last_burst ? ST_FLUSH : ST_AR;
                    end
                end
            end
            ST_FLUSH: begin
                if (!out_valid || out_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d = ST_AR;
            rem_d   = REM_W'(BLOCK_DEPTH + 1);
            cur_d   = start_word << DATA_BYTE_SHIFT;
        end
        // A pending request being served this cycle frees the slot for a new one.
        if (read_start && !(start && !pend_valid)) begin
            if (!pend_valid || start) begin
                store_req = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    axi_burst_planner u_planner (
        .remaining (rem_d),
        .cur_addr  (cur_d),
        .plan      (plan)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining     <= '0;
            cur_addr      <= '0;
            nxt_addr      <= '0;
            beat_cnt      <= '0;
            last_burst    <= 1'b0;
            pend_valid    <= 1'b0;
            pend_addr     <= '0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arvalid <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            drop          <= 1'b0;
        end else begin
            remaining <= rem_d;
            cur_addr  <= cur_d;
            done      <= done_d;
            drop      <= drop_d;

            if (store_req) begin
                pend_valid <= 1'b1;
                pend_addr  <= araddr_start;
            end else if (start && pend_valid) begin
                pend_valid <= 1'b0;
            end

            if (start) begin
                busy <= 1'b1;
                err  <= 1'b0;
            end else if (done_d) begin
                busy <= 1'b0;
            end

            if (beat) begin
                out_data  <= m_axi_rdata;
                out_valid <= 1'b1;
                out_last  <= (remaining == REM_W'(1));
                beat_cnt  <= beat_cnt - BEAT_W'(1);
                if (beat_err) begin
                    err <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            // Burst plan is latched on AR entry; must follow the beat update above.
            if ((state_d == ST_AR) && (state != ST_AR)) begin
                m_axi_arvalid <= 1'b1;
                m_axi_araddr  <= cur_d;
                m_axi_arlen   <= plan.arlen;
                beat_cnt      <= plan.beats;
                nxt_addr      <= plan.next_addr;
                last_burst    <= plan.last_burst;
            end else if (m_axi_arvalid && m_axi_arready) begin
                m_axi_arvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_threshold_block_axi_reader.sv
// Directed bench for threshold_block_axi_reader with a behavioural AXI read slave and stream sink.
module tb_threshold_block_axi_reader;
    import threshold_cutter_pkg::*;

    localparam int unsigned DW = 256;
    localparam int NWORDS = 401;
    localparam int NBURST = 26;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, read_start, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [31:0]   araddr_start, m_axi_araddr;
    logic [3:0]    m_axi_arid, m_axi_rid;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst, m_axi_rresp;
    logic          m_axi_arvalid;
    logic [DW-1:0] m_axi_rdata, out_data;
    logic          out_valid, out_ready, out_last, busy, done, err, drop;

    threshold_block_axi_reader dut (
        .clk(clk), .rst_n(rst_n), .read_start(read_start), .araddr_start(araddr_start),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done), .err(err), .drop(drop)
    );

    int vectors = 0;
    int miscompares = 0;

    // Slave/sink state and logs
    logic [31:0]   b_addr;
    int            b_left, b_beat, g_beat, cyc;
    bit            fault_resp, fault_rlast, rand_ready, marker_val;
    logic [31:0]   ar_addr_q[$];
    logic [7:0]    ar_len_q[$];
    int            ar_cyc_q[$];
    logic [DW-1:0] got_data[$];
    logic          got_last[$];
    int            done_cyc_q[$];
    int            done_cnt, drop_cnt, last_cyc, rr_viol, ovl_cnt;
    logic          err_at_done;

    function automatic logic [DW-1:0] exp_word(input logic [31:0] w, input bit mk);
        logic [DW-1:0] d;
        d = {8{w ^ 32'hA5A5_0000}};
        if (w[8:0] == 9'd400) d[0] = mk;
        return d;
    endfunction

    function automatic int data_errs(input int first, input logic [31:0] base, input bit mk);
        int n = 0;
        for (int k = 0; k < NWORDS; k++) begin
            if (first + k >= got_data.size()) n++;
            else if (got_data[first + k] !== exp_word(base + 32'(k), mk)) n++;
        end
        return n;
    endfunction

    function automatic int last_errs(input int first);
        int n = 0;
        for (int k = 0; k < NWORDS; k++) begin
            if (first + k >= got_last.size()) n++;
            else if (got_last[first + k] !== (k == NWORDS - 1)) n++;
        end
        return n;
    endfunction

    function automatic int ar_errs(input int first, input logic [31:0] base);
        int n = 0;
        for (int i = 0; i < NBURST; i++) begin
            if (first + i >= ar_addr_q.size()) n++;
            else if (ar_addr_q[first + i] !== (base << 5) + 32'(i * 512) ||
                     ar_len_q[first + i] !== ((i < NBURST - 1) ? 8'd15 : 8'd0)) n++;
        end
        return n;
    endfunction

    // AXI slave, stream sink and monitors: sample at negedge, drive just after posedge.
    initial begin
        bit ar_hs, r_hs, o_hs;
        logic [31:0] w;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        m_axi_rid = '0; m_axi_rdata = '0; out_ready = 1'b1;
        b_addr = '0; b_left = 0; b_beat = 0; g_beat = 0; cyc = 0;
        done_cnt = 0; drop_cnt = 0; last_cyc = 0; rr_viol = 0; ovl_cnt = 0; err_at_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            o_hs  = out_valid && out_ready;
            if (rst_n) begin
                if (ar_hs) begin
                    if (b_left != 0) ovl_cnt++;
                    ar_addr_q.push_back(m_axi_araddr);
                    ar_len_q.push_back(m_axi_arlen);
                    ar_cyc_q.push_back(cyc);
                end
                if (o_hs) begin
                    got_data.push_back(out_data);
                    got_last.push_back(out_last);
                    if (out_last) last_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc_q.push_back(cyc);
                    err_at_done = err;
                end
                if (drop) drop_cnt++;
                if (m_axi_rvalid && !m_axi_rready && (!out_valid || out_ready)) rr_viol++;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                b_left = 0;
            end else begin
                if (r_hs) begin b_beat++; b_left--; g_beat++; end
                if (ar_hs) begin b_addr = m_axi_araddr; b_left = int'(m_axi_arlen) + 1; b_beat = 0; end
            end
            w = (b_addr >> 5) + 32'(b_beat);
            m_axi_rvalid = (b_left != 0);
            m_axi_rdata  = exp_word(w, marker_val);
            m_axi_rlast  = (b_left == 1) && !(fault_rlast && (g_beat + 1 == 16));
            m_axi_rresp  = (fault_resp && (g_beat + 1 == 37)) ? 2'b10 : 2'b00;
            out_ready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic pulse_start(input logic [31:0] a);
        @(posedge clk); #1;
        read_start = 1'b1;
        araddr_start = a;
        @(posedge clk); #1;
        read_start = 1'b0;
    endtask

    task automatic clear_logs();
        ar_addr_q.delete(); ar_len_q.delete(); ar_cyc_q.delete();
        got_data.delete(); got_last.delete(); done_cyc_q.delete();
        g_beat = 0; rr_viol = 0; ovl_cnt = 0; drop_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; read_start = 1'b0; araddr_start = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (m_axi_arvalid !== 1'b0) begin miscompares++; $display("FAIL reset_arvalid: got %b want 0", m_axi_arvalid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if ({done, err, drop} !== 3'b000) begin miscompares++; $display("FAIL reset_done_err_drop: got %b want 000", {done, err, drop}); end
        vectors++; if ({out_valid, out_last} !== 2'b00) begin miscompares++; $display("FAIL reset_out: got %b want 00", {out_valid, out_last}); end
        vectors++; if (m_axi_rready !== 1'b0) begin miscompares++; $display("FAIL reset_rready: got %b want 0", m_axi_rready); end
        vectors++; if ({m_axi_araddr, m_axi_arlen} !== 40'h0) begin miscompares++; $display("FAIL reset_ar: got %h want 0", {m_axi_araddr, m_axi_arlen}); end
        vectors++; if ({m_axi_arsize, m_axi_arburst, m_axi_arid} !== {3'b101, 2'b01, 4'h0}) begin
            miscompares++; $display("FAIL ar_consts: got %b want 101010000", {m_axi_arsize, m_axi_arburst, m_axi_arid});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_block(input string name, input logic [31:0] base, input bit rnd,
                                     input bit fr, input bit fl, input bit mk, input logic exp_err);
        int d0, n;
        clear_logs();
        rand_ready = rnd; fault_resp = fr; fault_rlast = fl; marker_val = mk;
        d0 = done_cnt;
        pulse_start(base);
        vectors++; if ({busy, err} !== 2'b10) begin miscompares++; $display("FAIL %s_start_busy_err: got %b want 10", name, {busy, err}); end
        n = 0;
        while (done_cnt == d0 && n < 6000) begin @(posedge clk); n++; end
        vectors++; if (done_cnt == d0) begin miscompares++; $display("FAIL %s_done_timeout: got no done want done", name); end
        repeat (4) @(posedge clk);
        rand_ready = 1'b0;
        vectors++; if (done_cnt !== d0 + 1) begin miscompares++; $display("FAIL %s_done_count: got %0d want %0d", name, done_cnt - d0, 1); end
        vectors++; if (got_data.size() !== NWORDS) begin miscompares++; $display("FAIL %s_words: got %0d want %0d", name, got_data.size(), NWORDS); end
        n = data_errs(0, base, mk);
        vectors++; if (n !== 0) begin miscompares++; $display("FAIL %s_data: got %0d bad words want 0", name, n); end
        n = last_errs(0);
        vectors++; if (n !== 0) begin miscompares++; $display("FAIL %s_out_last: got %0d bad flags want 0", name, n); end
        vectors++; if (ar_addr_q.size() !== NBURST) begin miscompares++; $display("FAIL %s_ar_count: got %0d want %0d", name, ar_addr_q.size(), NBURST); end
        n = ar_errs(0, base);
        vectors++; if (n !== 0) begin miscompares++; $display("FAIL %s_ar_addr_len: got %0d bad ARs want 0", name, n); end
        vectors++; if (ovl_cnt !== 0) begin miscompares++; $display("FAIL %s_ar_overlap: got %0d want 0", name, ovl_cnt); end
        vectors++; if (rr_viol !== 0) begin miscompares++; $display("FAIL %s_rready_stall: got %0d want 0", name, rr_viol); end
        vectors++; if (err_at_done !== exp_err) begin miscompares++; $display("FAIL %s_err: got %b want %b", name, err_at_done, exp_err); end
        if (done_cyc_q.size() > 0) begin
            vectors++;
            if (done_cyc_q[0] - last_cyc !== 1) begin miscompares++; $display("FAIL %s_done_gap: got %0d want 1", name, done_cyc_q[0] - last_cyc); end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy_after: got %b want 0", name, busy); end
    endtask

    task automatic test_pending_drop();
        int d0, n;
        clear_logs();
        rand_ready = 1'b0; fault_resp = 1'b0; fault_rlast = 1'b0; marker_val = 1'b0;
        d0 = done_cnt;
        pulse_start(32'h200);
        repeat (3) @(posedge clk);
        pulse_start(32'h400);
        repeat (2) @(posedge clk);
        pulse_start(32'h600);
        n = 0;
        while (done_cnt < d0 + 2 && n < 8000) begin @(posedge clk); n++; end
        vectors++; if (done_cnt < d0 + 2) begin miscompares++; $display("FAIL pend_done_timeout: got %0d dones want 2", done_cnt - d0); end
        repeat (50) @(posedge clk);
        vectors++; if (drop_cnt !== 1) begin miscompares++; $display("FAIL pend_drop_count: got %0d want 1", drop_cnt); end
        vectors++; if (done_cnt !== d0 + 2) begin miscompares++; $display("FAIL pend_block_count: got %0d want 2", done_cnt - d0); end
        vectors++; if (got_data.size() !== 2 * NWORDS) begin miscompares++; $display("FAIL pend_words: got %0d want %0d", got_data.size(), 2 * NWORDS); end
        n = data_errs(0, 32'h200, 1'b0) + data_errs(NWORDS, 32'h400, 1'b0);
        vectors++; if (n !== 0) begin miscompares++; $display("FAIL pend_data: got %0d bad words want 0", n); end
        n = ar_errs(0, 32'h200) + ar_errs(NBURST, 32'h400);
        vectors++; if (n !== 0) begin miscompares++; $display("FAIL pend_ar: got %0d bad ARs want 0", n); end
        if (ar_cyc_q.size() > NBURST && done_cyc_q.size() > 0) begin
            vectors++;
            if (ar_cyc_q[NBURST] <= done_cyc_q[0]) begin
                miscompares++; $display("FAIL pend_order: got second AR at %0d want after done at %0d", ar_cyc_q[NBURST], done_cyc_q[0]);
            end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL pend_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_mid_reset();
        int d0;
        clear_logs();
        d0 = done_cnt;
        pulse_start(32'h200);
        repeat (3) @(posedge clk);
        pulse_start(32'h400);
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if ({busy, m_axi_arvalid, out_valid, m_axi_rready} !== 4'b0000) begin
            miscompares++; $display("FAIL midrst_outputs: got %b want 0000", {busy, m_axi_arvalid, out_valid, m_axi_rready});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        vectors++; if ({busy, m_axi_arvalid} !== 2'b00) begin miscompares++; $display("FAIL midrst_pending_cleared: got %b want 00", {busy, m_axi_arvalid}); end
        vectors++; if (done_cnt !== d0) begin miscompares++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt - d0); end
    endtask

    initial begin
        rand_ready = 1'b0; fault_resp = 1'b0; fault_rlast = 1'b0; marker_val = 1'b0;
        test_reset();
        test_single_block("nominal", 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_single_block("rand_ready", 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        test_single_block("rresp_err", 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        test_single_block("rlast_missing", 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef MARKER_CHECK_EN
        test_single_block("marker_ok", 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_single_block("marker_bad", 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
`else
        test_single_block("marker_unchecked", 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
        test_pending_drop();
        test_mid_reset();
        test_single_block("after_reset", 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
